// File: rtl/hzdu_pkg.sv
// Shared types for the hazard detection / interlock unit.
package hzdu_pkg;

    localparam int REGNO_W = 5;

    typedef enum logic {
        HZDU_RUN     = 1'b0,
        HZDU_MEMWAIT = 1'b1
    } hzdu_state_e;

    function automatic logic src_hit(
        input logic               used,
        input logic [REGNO_W-1:0] src,
        input logic [REGNO_W-1:0] dst
    );
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/hzdu_sat_cnt.sv
// Saturating up-counter with synchronous clear.
module sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hzdu.sv
// Load-use interlock and memory-wait freeze with bus timeout.
module hzdu
    import hzdu_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int TMO_WIDTH   = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p1_valid,
    input  logic [REGNO_W-1:0]   p1_rs,
    input  logic                 p1_rs_used,
    input  logic [REGNO_W-1:0]   p1_rt,
    input  logic                 p1_rt_used,
    input  logic                 p2_valid,
    input  logic                 p2_load,
    input  logic [REGNO_W-1:0]   p2_rd,
    input  logic                 p3_valid,
    input  logic                 p3_mem,
    input  logic                 dbus_rdy,
    input  logic                 stat_clr,
    output logic                 stall_p1,
    output logic                 bubble_p2,
    output logic                 stall_p3,
    output logic                 bus_tmo,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    hzdu_state_e          state_q, state_d;
    logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
    logic                 bus_tmo_q, bus_tmo_d;
    logic                 mwait, tmo_hit, ldu;
    logic                 s3, s1, b2;

    always_comb begin
        mwait   = p3_valid & p3_mem & ~dbus_rdy;
        tmo_hit = (tmo_q == TMO_WIDTH'(MEM_TIMEOUT - 1));
        ldu     = p1_valid & p2_valid & p2_load & (p2_rd != '0)
                & (src_hit(p1_rs_used, p1_rs, p2_rd)
                 | src_hit(p1_rt_used, p1_rt, p2_rd));

        state_d   = state_q;
        tmo_d     = tmo_q;
        bus_tmo_d = 1'b0;
        s3        = 1'b0;

        unique case (state_q)
            HZDU_RUN: begin
                s3 = mwait;
                if (mwait) begin
                    state_d = HZDU_MEMWAIT;
                    tmo_d   = '0;
                end
            end
            HZDU_MEMWAIT: begin
                s3 = ~dbus_rdy & ~tmo_hit;
                if (dbus_rdy) begin
                    state_d = HZDU_RUN;
                end else if (tmo_hit) begin
                    state_d   = HZDU_RUN;
                    bus_tmo_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_WIDTH'(1);
                end
            end
            default: state_d = HZDU_RUN;
        endcase

        // A memory freeze holds p2, so no bubble may be injected under it.
        s1 = ldu | s3;
        b2 = ldu & ~s3;

        if (rst) begin
            s3        = 1'b0;
            s1        = 1'b0;
            b2        = 1'b0;
            state_d   = HZDU_RUN;
            tmo_d     = '0;
            bus_tmo_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HZDU_RUN;
            tmo_q     <= '0;
            bus_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            bus_tmo_q <= bus_tmo_d;
        end
    end

    sat_cnt #(
        .W (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (stat_clr),
        .inc_i (s1),
        .cnt_o (stall_cnt)
    );

    assign stall_p1  = s1;
    assign bubble_p2 = b2;
    assign stall_p3  = s3;
    assign bus_tmo   = bus_tmo_q;

endmodule
